// File: rtl/stopwatch_display.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_display
//  Description : Stopwatch display stage. Samples binary minutes/seconds once
//                per display frame, converts both fields to BCD with a
//                shared-schedule shift-add-3 converter, and scans a 4-digit
//                common-anode multiplexed 7-segment display (mm.ss).
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_display #(
  parameter int CLK_HZ             = 50_000_000,
  parameter int REFRESH_HZ         = 1000,
  parameter int LEADING_ZERO_BLANK = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] minutes,
  input  logic [7:0] seconds,
  input  logic       enable,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_tick
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_DIV   = CLK_HZ / REFRESH_HZ;
  localparam int c_CNT_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_PRESC_MAX = c_CNT_W'(c_DIV - 1);

  // Digit register code used to request a dash on an out-of-range field
  localparam logic [3:0] c_DIG_DASH = 4'd10;
  localparam logic [7:0] c_FIELD_MAX = 8'd99;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] c_SEG_BLANK = 7'h7F;
  localparam logic [6:0] c_SEG_DASH  = 7'h3F;

  // The scan period must leave room for a full conversion inside one slot
  generate
    if (c_DIV < 16) begin : g_div_check
      $error("stopwatch_display: CLK_HZ/REFRESH_HZ must be >= 16");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Converter FSM states
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [c_CNT_W-1:0] r_presc;
  logic [1:0]         r_idx;
  logic               w_scan_tick;
  logic               w_frame_start;

  logic               r_frame_tick;
  logic [7:0]         r_min_s;
  logic [7:0]         r_sec_s;

  state_t             r_state;
  logic [2:0]         r_step;
  logic [19:0]        r_sh_min;
  logic [19:0]        r_sh_sec;
  logic [19:0]        w_dd_min;
  logic [19:0]        w_dd_sec;
  logic               r_min_ovr;
  logic               r_sec_ovr;

  logic [3:0]         r_dig0;
  logic [3:0]         r_dig1;
  logic [3:0]         r_dig2;
  logic [3:0]         r_dig3;

  logic [3:0]         w_digit;
  logic [6:0]         w_seg_enc;
  logic [3:0]         w_an_sel;
  logic               w_lz_blank;

  logic [6:0]         r_seg;
  logic               r_dp;
  logic [3:0]         r_an;

  // --------------------------------------------------------------------------
  // One shift-add-3 step over a {hundreds,tens,ones,binary} shift register
  // --------------------------------------------------------------------------
  function automatic logic [19:0] f_dd_step(input logic [19:0] i_v);
    logic [19:0] w_t;
    w_t = i_v;
    if (w_t[11:8] >= 4'd5) begin
      w_t[11:8] = w_t[11:8] + 4'd3;
    end
    if (w_t[15:12] >= 4'd5) begin
      w_t[15:12] = w_t[15:12] + 4'd3;
    end
    if (w_t[19:16] >= 4'd5) begin
      w_t[19:16] = w_t[19:16] + 4'd3;
    end
    return {w_t[18:0], 1'b0};
  endfunction

  // --------------------------------------------------------------------------
  // Scan timing
  // --------------------------------------------------------------------------
  assign w_scan_tick   = (r_presc == c_PRESC_MAX);
  assign w_frame_start = w_scan_tick && (r_idx == 2'd3);

  // Prescaler and digit index: index advances once per scan period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else if (w_scan_tick) begin
      r_presc <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Frame pulse and input sampling happen on the same frame-start edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_tick <= 1'b0;
      r_min_s      <= 8'd0;
      r_sec_s      <= 8'd0;
    end else begin
      r_frame_tick <= w_frame_start;
      if (w_frame_start) begin
        r_min_s <= minutes;
        r_sec_s <= seconds;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Binary to BCD conversion
  // --------------------------------------------------------------------------
  assign w_dd_min = f_dd_step(r_sh_min);
  assign w_dd_sec = f_dd_step(r_sh_sec);

  // Converter FSM: start after frame pulse, 8 parallel steps, then one load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_step    <= 3'd0;
      r_sh_min  <= 20'd0;
      r_sh_sec  <= 20'd0;
      r_min_ovr <= 1'b0;
      r_sec_ovr <= 1'b0;
      r_dig0    <= 4'd0;
      r_dig1    <= 4'd0;
      r_dig2    <= 4'd0;
      r_dig3    <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_frame_tick) begin
            r_sh_min  <= {12'd0, r_min_s};
            r_sh_sec  <= {12'd0, r_sec_s};
            r_min_ovr <= (r_min_s > c_FIELD_MAX);
            r_sec_ovr <= (r_sec_s > c_FIELD_MAX);
            r_step    <= 3'd0;
            r_state   <= S_CONV;
          end
        end
        S_CONV: begin
          r_sh_min <= w_dd_min;
          r_sh_sec <= w_dd_sec;
          r_step   <= r_step + 3'd1;
          if (r_step == 3'd7) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // All four digits change together so the display never tears
          r_dig0  <= r_sec_ovr ? c_DIG_DASH : r_sh_sec[11:8];
          r_dig1  <= r_sec_ovr ? c_DIG_DASH : r_sh_sec[15:12];
          r_dig2  <= r_min_ovr ? c_DIG_DASH : r_sh_min[11:8];
          r_dig3  <= r_min_ovr ? c_DIG_DASH : r_sh_min[15:12];
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Digit select, segment encode, anode decode
  // --------------------------------------------------------------------------
  // Pick the digit for the current scan slot
  always_comb begin
    w_digit = r_dig0;
    case (r_idx)
      2'd0:    w_digit = r_dig0;
      2'd1:    w_digit = r_dig1;
      2'd2:    w_digit = r_dig2;
      2'd3:    w_digit = r_dig3;
      default: w_digit = r_dig0;
    endcase
  end

  // Active-low 7-segment encoding of the selected digit
  always_comb begin
    w_seg_enc = c_SEG_BLANK;
    case (w_digit)
      4'd0:       w_seg_enc = 7'h40;
      4'd1:       w_seg_enc = 7'h79;
      4'd2:       w_seg_enc = 7'h24;
      4'd3:       w_seg_enc = 7'h30;
      4'd4:       w_seg_enc = 7'h19;
      4'd5:       w_seg_enc = 7'h12;
      4'd6:       w_seg_enc = 7'h02;
      4'd7:       w_seg_enc = 7'h78;
      4'd8:       w_seg_enc = 7'h00;
      4'd9:       w_seg_enc = 7'h10;
      c_DIG_DASH: w_seg_enc = c_SEG_DASH;
      default:    w_seg_enc = c_SEG_BLANK;
    endcase
  end

  // One-hot-low anode for the current slot; an[0] is the rightmost digit
  always_comb begin
    w_an_sel = 4'hF;
    case (r_idx)
      2'd0:    w_an_sel = 4'b1110;
      2'd1:    w_an_sel = 4'b1101;
      2'd2:    w_an_sel = 4'b1011;
      2'd3:    w_an_sel = 4'b0111;
      default: w_an_sel = 4'hF;
    endcase
  end

  assign w_lz_blank = (LEADING_ZERO_BLANK != 0) && (r_idx == 2'd3) &&
                      (r_dig3 == 4'd0);

  // Registered display pins; blanking forces every pin inactive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 4'hF;
      r_seg <= c_SEG_BLANK;
      r_dp  <= 1'b1;
    end else if (!enable || w_lz_blank) begin
      r_an  <= 4'hF;
      r_seg <= c_SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_sel;
      r_seg <= w_seg_enc;
      r_dp  <= (r_idx != 2'd2);
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_display
//  Description : Directed self-checking bench for stopwatch_display, with one
//                instance per leading-zero-blank setting (DIV = 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       enable;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [3:0] an0, an1;
  logic       ft0, ft1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stopwatch_display #(
    .CLK_HZ(1600), .REFRESH_HZ(100), .LEADING_ZERO_BLANK(0)
  ) dut0 (
    .clk(clk), .reset(reset), .minutes(minutes), .seconds(seconds),
    .enable(enable), .seg(seg0), .dp(dp0), .an(an0), .frame_tick(ft0)
  );

  stopwatch_display #(
    .CLK_HZ(1600), .REFRESH_HZ(100), .LEADING_ZERO_BLANK(1)
  ) dut1 (
    .clk(clk), .reset(reset), .minutes(minutes), .seconds(seconds),
    .enable(enable), .seg(seg1), .dp(dp1), .an(an1), .frame_tick(ft1)
  );

  // Negedge count after a frame pulse at which slot s shows freshly loaded data
  function automatic int slot_off(input int s);
    return (s == 0) ? 12 : (16 * s + 4);
  endfunction

  // Waits (bounded) for the frame pulse; returns at the negedge where it is seen
  task automatic wait_ft(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ft0 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; minutes = 8'd0; seconds = 8'd0;
    repeat (3) @(negedge clk);
    checks++; if (an0 !== 4'hF) begin errors++; $display("FAIL reset_an: got %h expected F", an0); end
    checks++; if (seg0 !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h expected 7F", seg0); end
    checks++; if (dp0 !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b expected 1", dp0); end
    checks++; if (ft0 !== 1'b0 || ft1 !== 1'b0) begin errors++; $display("FAIL reset_ft: got %b%b expected 00", ft0, ft1); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (an0 !== 4'hE) begin errors++; $display("FAIL release_an: got %h expected E", an0); end
    checks++; if (seg0 !== 7'h40) begin errors++; $display("FAIL release_seg: got %h expected 40", seg0); end
    checks++; if (dp0 !== 1'b1) begin errors++; $display("FAIL release_dp: got %b expected 1", dp0); end
  endtask

  task automatic test_digits();
    bit ok; int cur;
    logic [3:0] ea[4]; logic [6:0] es[4]; logic ed[4];
    ea = '{4'hE, 4'hD, 4'hB, 4'h7};
    es = '{7'h19, 7'h30, 7'h24, 7'h79};
    ed = '{1'b1, 1'b1, 1'b0, 1'b1};
    minutes = 8'd12; seconds = 8'd34;
    wait_ft(ok);
    checks++; if (!ok) begin errors++; $display("FAIL digits_ft: got timeout expected frame_tick"); end
    cur = 0;
    for (int s = 0; s < 4; s++) begin
      repeat (slot_off(s) - cur) @(negedge clk);
      cur = slot_off(s);
      checks++; if (an0 !== ea[s]) begin errors++; $display("FAIL digits_an%0d: got %h expected %h", s, an0, ea[s]); end
      checks++; if (seg0 !== es[s]) begin errors++; $display("FAIL digits_seg%0d: got %h expected %h", s, seg0, es[s]); end
      checks++; if (dp0 !== ed[s]) begin errors++; $display("FAIL digits_dp%0d: got %b expected %b", s, dp0, ed[s]); end
      checks++; if (seg1 !== es[s] || an1 !== ea[s] || dp1 !== ed[s]) begin
        errors++; $display("FAIL digits_lzb%0d: got %h/%h/%b expected %h/%h/%b", s, seg1, an1, dp1, es[s], ea[s], ed[s]);
      end
    end
  endtask

  task automatic test_range();
    bit ok; int cur;
    logic [6:0] es[4];
    es = '{7'h3F, 7'h3F, 7'h10, 7'h10};
    minutes = 8'd99; seconds = 8'd100;
    wait_ft(ok);
    checks++; if (!ok) begin errors++; $display("FAIL range_ft: got timeout expected frame_tick"); end
    cur = 0;
    for (int s = 0; s < 4; s++) begin
      repeat (slot_off(s) - cur) @(negedge clk);
      cur = slot_off(s);
      checks++; if (seg0 !== es[s]) begin errors++; $display("FAIL range_seg%0d: got %h expected %h", s, seg0, es[s]); end
    end
  endtask

  task automatic test_lzb();
    bit ok; int cur;
    minutes = 8'd5; seconds = 8'd7;
    wait_ft(ok);
    checks++; if (!ok) begin errors++; $display("FAIL lzb_ft: got timeout expected frame_tick"); end
    cur = 0;
    repeat (slot_off(0) - cur) @(negedge clk); cur = slot_off(0);
    checks++; if (seg1 !== 7'h78) begin errors++; $display("FAIL lzb_slot0: got %h expected 78", seg1); end
    repeat (slot_off(2) - cur) @(negedge clk); cur = slot_off(2);
    checks++; if (seg1 !== 7'h12 || an1 !== 4'hB) begin errors++; $display("FAIL lzb_slot2: got %h/%h expected 12/B", seg1, an1); end
    repeat (slot_off(3) - cur) @(negedge clk); cur = slot_off(3);
    checks++; if (an1 !== 4'hF || seg1 !== 7'h7F) begin errors++; $display("FAIL lzb_slot3: got %h/%h expected F/7F", an1, seg1); end
    checks++; if (an0 !== 4'h7 || seg0 !== 7'h40) begin errors++; $display("FAIL nolzb_slot3: got %h/%h expected 7/40", an0, seg0); end
  endtask

  task automatic test_hold();
    bit ok; int cur;
    logic [6:0] es[4];
    es = '{7'h00, 7'h78, 7'h02, 7'h12};
    minutes = 8'd12; seconds = 8'd34;
    wait_ft(ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_ftA: got timeout expected frame_tick"); end
    repeat (30) @(negedge clk);
    minutes = 8'd56; seconds = 8'd78;
    repeat (6) @(negedge clk);
    checks++; if (seg0 !== 7'h24) begin errors++; $display("FAIL hold_midframe: got %h expected 24", seg0); end
    wait_ft(ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_ftB: got timeout expected frame_tick"); end
    repeat (10) @(negedge clk);
    checks++; if (seg0 !== 7'h19 || an0 !== 4'hE) begin errors++; $display("FAIL hold_before_load: got %h/%h expected 19/E", seg0, an0); end
    @(negedge clk);
    checks++; if (seg0 !== 7'h00) begin errors++; $display("FAIL hold_at_load: got %h expected 00", seg0); end
    cur = 11;
    for (int s = 1; s < 4; s++) begin
      repeat (slot_off(s) - cur) @(negedge clk);
      cur = slot_off(s);
      checks++; if (seg0 !== es[s]) begin errors++; $display("FAIL hold_seg%0d: got %h expected %h", s, seg0, es[s]); end
    end
  endtask

  task automatic test_enable();
    bit ok; int cnt;
    enable = 1'b0;
    @(negedge clk);
    checks++; if (an0 !== 4'hF || seg0 !== 7'h7F || dp0 !== 1'b1) begin
      errors++; $display("FAIL enable_off: got %h/%h/%b expected F/7F/1", an0, seg0, dp0);
    end
    wait_ft(ok);
    checks++; if (!ok) begin errors++; $display("FAIL enable_ft: got timeout expected frame_tick"); end
    cnt = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cnt++;
      if (cnt == 20 || cnt == 40) begin
        checks++; if (an0 !== 4'hF || seg0 !== 7'h7F || dp0 !== 1'b1) begin
          errors++; $display("FAIL enable_blank%0d: got %h/%h/%b expected F/7F/1", cnt, an0, seg0, dp0);
        end
      end
      if (ft0 === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || cnt != 64) begin errors++; $display("FAIL enable_period: got %0d expected 64", cnt); end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (an0 !== 4'hE) begin errors++; $display("FAIL enable_on: got %h expected E", an0); end
  endtask

  task automatic test_reset_conv();
    bit ok; int cur; int cnt;
    logic [3:0] ea[4]; logic ed[4];
    ea = '{4'hE, 4'hD, 4'hB, 4'h7};
    ed = '{1'b1, 1'b1, 1'b0, 1'b1};
    minutes = 8'd12; seconds = 8'd34;
    wait_ft(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rconv_ft: got timeout expected frame_tick"); end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (an0 !== 4'hF || seg0 !== 7'h7F || dp0 !== 1'b1 || ft0 !== 1'b0) begin
      errors++; $display("FAIL rconv_async: got %h/%h/%b/%b expected F/7F/1/0", an0, seg0, dp0, ft0);
    end
    @(negedge clk);
    reset = 1'b0;
    cur = 0;
    for (int s = 0; s < 4; s++) begin
      repeat (slot_off(s) - cur) @(negedge clk);
      cur = slot_off(s);
      checks++; if (seg0 !== 7'h40 || an0 !== ea[s] || dp0 !== ed[s]) begin
        errors++; $display("FAIL rconv_zero%0d: got %h/%h/%b expected 40/%h/%b", s, seg0, an0, dp0, ea[s], ed[s]);
      end
    end
    cnt = cur; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (ft0 === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || cnt != 64) begin errors++; $display("FAIL rconv_first_ft: got %0d expected 64", cnt); end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_range();
    test_lzb();
    test_hold();
    test_enable();
    test_reset_conv();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
